uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ requesters. Each requester sends packets of 9-bit words. Arbitration is round-robin at packet granularity, and a burst cap prevents one requester from hogging the line. The block sits between the per-channel TX FIFOs and the UART transmitter's valid/ready/done interface, and inserts a programmable idle guard gap between frames.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 9, word width passed to the transmitter
CNT_W, 16, width of the guard and stall counters

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_req_valid  in  NUM_REQ  per-requester word valid
o_req_ready  out  NUM_REQ  per-requester word accepted
i_req_data  in  NUM_REQ*DATA_W  per-requester word, requester k at bits [k*DATA_W +: DATA_W]
i_req_last  in  NUM_REQ  word is the last of its packet
o_tx_valid  out  1  word valid to the transmitter
i_tx_ready  in  1  transmitter idle and accepting
o_tx_data  out  DATA_W  word to the transmitter
i_tx_done  in  1  one-cycle pulse at end of frame (after the stop bit)
i_enable  in  1  arbitration enable
i_guard_cycles  in  CNT_W  idle clocks after each frame; 0 means no gap
i_max_burst  in  8  maximum words per grant; 0 means unlimited
i_stall_limit  in  CNT_W  clocks a granted requester may idle mid-packet; 0 disables
o_grant  out  NUM_REQ  one-hot current owner; 0 when no owner
o_grant_id  out  $clog2(NUM_REQ)  index of current or last owner
o_busy  out  1  state is not IDLE
o_stall_err  out  1  one-cycle pulse when a grant is revoked by stall timeout

Behaviour:
- Reset values: state IDLE, o_grant=0, o_grant_id=NUM_REQ-1, all ready/valid low, o_tx_data=0, o_busy=0, o_stall_err=0, counters 0. Reset mid-frame drops the grant immediately; the partially sent packet is abandoned.
- FSM states: IDLE, SEND, WAIT_DONE, GUARD.
- IDLE:
  - If i_enable and any i_req_valid, pick the first valid requester scanning from o_grant_id+1 modulo NUM_REQ.
  - Register the pick into o_grant and o_grant_id, clear the burst counter, and go to SEND next cycle. Grant latency is exactly 1 clock.
- SEND:
  - o_tx_valid = i_req_valid[grant]; o_tx_data = i_req_data[grant] (combinational mux).
  - o_req_ready[grant] = i_tx_ready; every other ready bit is 0.
  - On handshake (valid && ready): latch the last flag, increment the burst counter, go to WAIT_DONE.
- WAIT_DONE: on i_tx_done, go to GUARD if i_guard_cycles≠0, else evaluate release in the same cycle.
- GUARD: count i_guard_cycles clocks with o_tx_valid=0, then evaluate release.
- Release evaluation:
  - Release if the latched last=1, or if i_max_burst≠0 and burst count == i_max_burst, or if i_enable=0. Release clears o_grant to 0 and goes to IDLE; o_grant_id keeps the last owner for round-robin.
  - Otherwise return to SEND with the same grant.
- Stall timeout:
  - In SEND, the stall counter increments each clock the granted i_req_valid=0 and clears on valid.
  - When it reaches i_stall_limit (≠0): pulse o_stall_err, release the grant, go to IDLE.
  - The first SEND after a new grant is also covered.
- The burst cap applies mid-packet. The requester keeps its packet position and resumes when next granted, since ordering per channel is preserved and the UART is byte-stream.
- i_enable deasserting never aborts the word in flight. It takes effect at the next release evaluation.
- i_tx_done while not in WAIT_DONE is ignored.
- Config inputs are sampled live. Software changes them only when o_busy=0.
- Only one requester is ever granted; o_grant is always one-hot or zero.

Test Plan:
- Single requester: req1 sends a 3-word packet {0x041,0x042,0x1C3 last}, guard=0 → o_grant=0b0010 one clock after valid; three tx handshakes in order, each preceded by i_tx_done of the previous frame; o_grant=0 after the third done.
- Round-robin: all 4 requesters valid with 1-word packets, starting from reset → grant order 0,1,2,3,0; no requester is granted twice while another is waiting.
- Burst cap: i_max_burst=2, req0 has a 5-word packet and req2 a 1-word packet → order req0×2, req2×1, req0×2, req0×1.
- Guard: i_guard_cycles=10 → exactly 10 clocks with o_tx_valid=0 between the i_tx_done pulse and the next o_tx_valid.
- Stall: i_stall_limit=20, req3 sends 1 word of a packet then drops valid → o_stall_err pulses 20 clocks after entering SEND; grant releases; pending req0 is granted next.
- Reset mid-packet: assert i_rst during WAIT_DONE → all outputs at reset values asynchronously; after deassert, the first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ packet sources.
// Round-robin arbitration at packet granularity, with an optional burst cap, an
// idle guard gap after each frame and a mid-packet stall timeout.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready per-requester word handshake
//   i_req_data, i_req_last  per-requester word (k at [k*DATA_W +: DATA_W]) and end-of-packet
//   o_tx_valid/i_tx_ready   word handshake towards the transmitter
//   o_tx_data               word to the transmitter
//   i_tx_done               end-of-frame pulse from the transmitter
//   i_enable                arbitration enable, honoured at release points
//   i_guard_cycles          idle clocks after each frame (0 = none)
//   i_max_burst             words per grant (0 = unlimited)
//   i_stall_limit           idle clocks tolerated mid-packet while granted (0 = off)
//   o_grant, o_grant_id     one-hot owner (0 when none) and current/last owner index
//   o_busy                  arbiter is not idle
//   o_stall_err             one-cycle pulse when a grant is revoked by stall timeout
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  input  logic                      i_enable,
  input  logic [CNT_W-1:0]          i_guard_cycles,
  input  logic [7:0]                i_max_burst,
  input  logic [CNT_W-1:0]          i_stall_limit,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy,
  output logic                      o_stall_err
);

  typedef enum logic [1:0] {StIdle, StSend, StWaitDone, StGuard} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [7:0]         burst_q;
  logic [CNT_W-1:0]   guard_q;
  logic [CNT_W-1:0]   stall_q;
  logic               last_q;
  logic               stall_err_q;

  logic [DATA_W-1:0]  req_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign req_word[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester after the last owner.
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(grant_id_q) + 32'd1 + i) % NUM_REQ);
      if (!pick_found && i_req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  logic send;
  logic cur_valid;
  logic hs;
  logic release_now;
  logic stall_hit;
  logic guard_end;

  assign send      = (state_q == StSend);
  assign cur_valid = i_req_valid[grant_id_q];
  assign hs        = send && cur_valid && i_tx_ready;

  // A burst-capped requester keeps its packet position and resumes on its next grant.
  assign release_now = last_q || ((i_max_burst != 8'd0) && (burst_q == i_max_burst)) ||
                       !i_enable;
  assign stall_hit   = (i_stall_limit != '0) && ((stall_q + CNT_W'(1)) == i_stall_limit);
  assign guard_end   = (guard_q + CNT_W'(1)) >= i_guard_cycles;

  assign o_tx_valid  = send && cur_valid;
  assign o_tx_data   = send ? req_word[grant_id_q] : '0;
  assign o_req_ready = {NUM_REQ{send & i_tx_ready}} & grant_q;
  assign o_grant     = grant_q;
  assign o_grant_id  = grant_id_q;
  assign o_busy      = (state_q != StIdle);
  assign o_stall_err = stall_err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_id_q  <= ID_W'(NUM_REQ - 1);
      burst_q     <= '0;
      guard_q     <= '0;
      stall_q     <= '0;
      last_q      <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      stall_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_enable && pick_found) begin
            grant_q          <= '0;
            grant_q[pick_id] <= 1'b1;
            grant_id_q       <= pick_id;
            burst_q          <= '0;
            stall_q          <= '0;
            last_q           <= 1'b0;
            state_q          <= StSend;
          end
        end
        StSend: begin
          if (hs) begin
            last_q  <= i_req_last[grant_id_q];
            burst_q <= burst_q + 8'd1;
            stall_q <= '0;
            state_q <= StWaitDone;
          end else if (cur_valid) begin
            stall_q <= '0;
          end else if (stall_hit) begin
            stall_err_q <= 1'b1;
            grant_q     <= '0;
            stall_q     <= '0;
            state_q     <= StIdle;
          end else begin
            stall_q <= stall_q + CNT_W'(1);
          end
        end
        StWaitDone: begin
          if (i_tx_done) begin
            if (i_guard_cycles != '0) begin
              guard_q <= '0;
              state_q <= StGuard;
            end else if (release_now) begin
              grant_q <= '0;
              state_q <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end
        end
        StGuard: begin
          if (guard_end) begin
            if (release_now) begin
              grant_q <= '0;
              state_q <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end else begin
            guard_q <= guard_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 9;
  localparam int CNT_W   = 16;
  localparam int FRAME   = 6;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      enable;
  logic [CNT_W-1:0]          guard_cycles;
  logic [7:0]                max_burst;
  logic [CNT_W-1:0]          stall_limit;
  logic [NUM_REQ-1:0]        grant;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      stall_err;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_data    (req_data),
    .i_req_last    (req_last),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_tx_data     (tx_data),
    .i_tx_done     (tx_done),
    .i_enable      (enable),
    .i_guard_cycles(guard_cycles),
    .i_max_burst   (max_burst),
    .i_stall_limit (stall_limit),
    .o_grant       (grant),
    .o_grant_id    (grant_id),
    .o_busy        (busy),
    .o_stall_err   (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Scoreboard of expected transmitter words in output order.
  typedef struct {
    int         id;
    logic [8:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Per-requester word sources: {last, data}; valid drops once ptr reaches stop.
  logic [9:0] src_mem [NUM_REQ][32];
  int         src_cnt [NUM_REQ];
  int         src_ptr [NUM_REQ];
  int         src_stop[NUM_REQ];

  task automatic add_word(input int k, input logic [8:0] d, input logic last);
    src_mem[k][src_cnt[k]] = {last, d};
    src_cnt[k]++;
  endtask

  task automatic expect_tx(input int k, input logic [8:0] d);
    exp_t x;
    x.id   = k;
    x.data = d;
    sb.push_back(x);
  endtask

  // Values captured on the falling edge, consumed just after the next rising edge.
  logic [NUM_REQ-1:0] acc;
  bit                 hs_tx;
  int                 tx_cnt;
  int                 hs_cnt;
  bit                 gap_arm;
  int                 gap_cnt;
  int                 last_gap;
  int                 since_done;
  int                 err_cnt;
  int                 err_gap;
  logic [3:0]         err_grant;

  // Monitor: sample settled outputs on the falling edge.
  initial begin
    acc = '0; hs_tx = 1'b0; hs_cnt = 0; gap_arm = 1'b0; gap_cnt = 0; last_gap = -1;
    since_done = 0; err_cnt = 0; err_gap = -1; err_grant = '1;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc     = '0;
        hs_tx   = 1'b0;
        gap_arm = 1'b0;
      end else begin
        acc   = req_valid & req_ready;
        hs_tx = tx_valid && tx_ready;
        if (hs_tx) begin
          chk("sb_nonempty", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("tx_id", int'(grant_id), e.id);
            chk("tx_data", int'(tx_data), int'(e.data));
            chk("tx_grant_1hot", int'(grant), 1 << e.id);
          end
          hs_cnt++;
        end
        if (tx_done) begin
          gap_arm    = 1'b1;
          gap_cnt    = 0;
          since_done = 0;
        end else begin
          since_done++;
          if (gap_arm) begin
            if (tx_valid) begin
              last_gap = gap_cnt;
              gap_arm  = 1'b0;
            end else begin
              gap_cnt++;
            end
          end
        end
        if (stall_err) begin
          err_cnt++;
          err_gap   = since_done;
          err_grant = grant;
        end
      end
    end
  end

  // Drivers: transmitter model and requester sources, updated 1 unit after the rising edge.
  initial begin
    tx_ready = 1'b1; tx_done = 1'b0; tx_cnt = 0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int k = 0; k < NUM_REQ; k++) src_ptr[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (rst) begin
        tx_cnt   = 0;
        tx_ready = 1'b1;
      end else if (hs_tx) begin
        tx_cnt   = FRAME;
        tx_ready = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done  = 1'b1;
          tx_ready = 1'b1;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc[k] && !rst) src_ptr[k]++;
        req_valid[k] = (src_ptr[k] < src_cnt[k]) && (src_ptr[k] < src_stop[k]);
        if (src_ptr[k] < src_cnt[k]) begin
          req_data[k*DATA_W +: DATA_W] = src_mem[k][src_ptr[k]][8:0];
          req_last[k]                  = src_mem[k][src_ptr[k]][9];
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || tx_cnt != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_grant_id"}, int'(grant_id), NUM_REQ - 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_tx_valid"}, int'(tx_valid), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_stall_err"}, int'(stall_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;
    int h0;
    checks = 0; errors = 0;
    rst = 1'b1; enable = 1'b1; guard_cycles = '0; max_burst = '0; stall_limit = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      src_cnt[k]  = 0;
      src_stop[k] = 1000;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);

    // Single requester, 3-word packet, no guard.
    add_word(1, 9'h041, 1'b0); add_word(1, 9'h042, 1'b0); add_word(1, 9'h1C3, 1'b1);
    expect_tx(1, 9'h041); expect_tx(1, 9'h042); expect_tx(1, 9'h1C3);
    @(negedge clk);
    chk("t1_valid_seen", int'(req_valid[1]), 1);
    chk("t1_grant_before", int'(grant), 0);
    @(negedge clk);
    chk("t1_grant_latency", int'(grant), 4'b0010);
    wait_quiet("t1", 200);
    chk("t1_grant_released", int'(grant), 0);
    chk("t1_grant_id_kept", int'(grant_id), 1);
    chk("t1_gap_zero", last_gap, 0);

    // Round-robin from reset: 0,1,2,3,0.
    do_reset();
    add_word(0, 9'h100, 1'b1); add_word(1, 9'h101, 1'b1); add_word(2, 9'h102, 1'b1);
    add_word(3, 9'h103, 1'b1); add_word(0, 9'h104, 1'b1);
    expect_tx(0, 9'h100); expect_tx(1, 9'h101); expect_tx(2, 9'h102);
    expect_tx(3, 9'h103); expect_tx(0, 9'h104);
    wait_quiet("t2", 300);

    // Burst cap of 2: req0 x2, req2, req0 x2, req0.
    do_reset();
    max_burst = 8'd2;
    for (int i = 0; i < 5; i++) add_word(0, 9'(9'h010 + i), (i == 4));
    add_word(2, 9'h020, 1'b1);
    expect_tx(0, 9'h010); expect_tx(0, 9'h011); expect_tx(2, 9'h020);
    expect_tx(0, 9'h012); expect_tx(0, 9'h013); expect_tx(0, 9'h014);
    wait_quiet("t3", 400);
    max_burst = 8'd0;

    // Guard gap of 10 idle clocks between done and next valid.
    guard_cycles = 16'd10;
    add_word(1, 9'h055, 1'b0); add_word(1, 9'h056, 1'b1);
    expect_tx(1, 9'h055); expect_tx(1, 9'h056);
    wait_quiet("t4", 300);
    chk("t4_guard_gap", last_gap, 10);
    guard_cycles = '0;

    // Stall timeout: req3 sends one word then goes quiet; req0 waits.
    do_reset();
    stall_limit = 16'd20;
    e0 = err_cnt;
    src_stop[3] = src_cnt[3] + 1;
    add_word(3, 9'h0A1, 1'b0); add_word(3, 9'h0A2, 1'b1);
    expect_tx(3, 9'h0A1);
    n = 0;
    while (grant != 4'b1000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_grant_req3", int'(grant), 4'b1000);
    add_word(0, 9'h0B0, 1'b1);
    expect_tx(0, 9'h0B0);
    wait_quiet("t5", 300);
    chk("t5_err_pulses", err_cnt - e0, 1);
    // done cycle, then 20 SEND clocks, then the pulse cycle
    chk("t5_err_timing", err_gap, 21);
    chk("t5_err_grant", int'(err_grant), 0);
    stall_limit = '0;

    // Reset while waiting for frame done; first grant afterwards goes to req0.
    add_word(2, 9'h0C1, 1'b0); add_word(2, 9'h0C2, 1'b1);
    expect_tx(2, 9'h0C1);
    h0 = hs_cnt;
    n = 0;
    while (hs_cnt == h0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_word_sent", hs_cnt - h0, 1);
    repeat (2) @(posedge clk);
    #3;
    chk("t6_busy_before_rst", int'(busy), 1);
    chk("t6_grant_before_rst", int'(grant), 4'b0100);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    add_word(0, 9'h0D0, 1'b1);
    expect_tx(0, 9'h0D0); expect_tx(2, 9'h0C2);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_first_grant", int'(grant), 4'b0001);
    wait_quiet("t6", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
